// File: rtl/cp0_regfile_pkg.sv
// Shared CP0 constants: WB-to-CP0 bus layout, register addresses, exception codes.
package cp0_regfile_pkg;

  localparam int WB_TO_CP0_REGISTER_BUS_WD = 110;

  localparam logic [4:0] CR_BADVADDR = 5'd8;
  localparam logic [4:0] CR_COUNT    = 5'd9;
  localparam logic [4:0] CR_COMPARE  = 5'd11;
  localparam logic [4:0] CR_STATUS   = 5'd12;
  localparam logic [4:0] CR_CAUSE    = 5'd13;
  localparam logic [4:0] CR_EPC      = 5'd14;

  localparam logic [4:0] EXC_INT  = 5'h00;
  localparam logic [4:0] EXC_ADEL = 5'h04;
  localparam logic [4:0] EXC_ADES = 5'h05;
  localparam logic [4:0] EXC_SYS  = 5'h08;
  localparam logic [4:0] EXC_BP   = 5'h09;
  localparam logic [4:0] EXC_RI   = 5'h0a;
  localparam logic [4:0] EXC_OV   = 5'h0c;

  localparam logic [31:0] STATUS_RESET = 32'h0040_0000;

  typedef struct packed {
    logic        ex;
    logic [4:0]  excode;
    logic [31:0] badvaddr;
    logic        bd;
    logic [31:0] pc;
    logic        mtc0_we;
    logic [4:0]  addr;
    logic [31:0] wdata;
    logic        eret;
  } wb_cp0_bus_t;

  function automatic logic is_addr_exc(input logic [4:0] excode);
    return (excode == EXC_ADEL) || (excode == EXC_ADES);
  endfunction

endpackage

// File: rtl/cp0_timer.sv
// Count/Compare timer: Count advances every other cycle, TI latches on a match
// and is cleared only by a write to Compare.
module cp0_timer
  import cp0_regfile_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        count_we,
  input  logic        compare_we,
  input  logic [31:0] wdata,
  output logic [31:0] count,
  output logic [31:0] compare,
  output logic        ti
);

  logic tick;

  always_ff @(posedge clk) begin
    if (reset) begin
      tick    <= 1'b0;
      count   <= 32'd0;
      compare <= 32'd0;
      ti      <= 1'b0;
    end else begin
      tick <= ~tick;
      if (count_we)
        count <= wdata;
      else if (tick)
        count <= count + 32'd1;
      if (compare_we)
        compare <= wdata;
      // Clearing on a Compare write takes precedence over a same-cycle match.
      if (compare_we)
        ti <= 1'b0;
      else if (count == compare)
        ti <= 1'b1;
    end
  end

endmodule

// File: rtl/cp0_regfile.sv
// CP0 register file fed by write-back: exception entry, ERET, MTC0 writes,
// MFC0 reads, interrupt-pending generation and EPC for the ERET redirect.
module cp0_regfile
  import cp0_regfile_pkg::*;
(
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [WB_TO_CP0_REGISTER_BUS_WD-1:0] wb_to_cp0_register_bus,
  input  logic [5:0]                           ext_int_in,
  output logic [31:0]                          cp0_rdata,
  output logic [31:0]                          cp0_epc,
  output logic                                 has_int
);

  wb_cp0_bus_t bus;
  assign bus = wb_to_cp0_register_bus;

  logic do_ex, do_eret, do_mtc0;
  assign do_ex   = bus.ex & ~bus.eret;
  assign do_eret = bus.eret;
  assign do_mtc0 = bus.mtc0_we & ~bus.ex & ~bus.eret;

  logic [7:0]  status_im;
  logic        status_exl;
  logic        status_ie;
  logic        cause_bd;
  logic [5:0]  cause_ip_hw;
  logic [1:0]  cause_ip_sw;
  logic [4:0]  cause_excode;
  logic [31:0] epc;
  logic [31:0] badvaddr;

  logic [31:0] count, compare;
  logic        ti;

  cp0_timer u_timer (
    .clk        (clk),
    .reset      (reset),
    .count_we   (do_mtc0 && (bus.addr == CR_COUNT)),
    .compare_we (do_mtc0 && (bus.addr == CR_COMPARE)),
    .wdata      (bus.wdata),
    .count      (count),
    .compare    (compare),
    .ti         (ti)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      status_im    <= 8'd0;
      status_exl   <= 1'b0;
      status_ie    <= 1'b0;
      cause_bd     <= 1'b0;
      cause_ip_hw  <= 6'd0;
      cause_ip_sw  <= 2'd0;
      cause_excode <= 5'd0;
      epc          <= 32'd0;
      badvaddr     <= 32'd0;
    end else begin
      // The timer interrupt shares IP7 with the highest external line.
      cause_ip_hw <= {ext_int_in[5] | ti, ext_int_in[4:0]};
      if (do_ex) begin
        if (!status_exl) begin
          epc      <= bus.bd ? bus.pc - 32'd4 : bus.pc;
          cause_bd <= bus.bd;
        end
        cause_excode <= bus.excode;
        status_exl   <= 1'b1;
        if (is_addr_exc(bus.excode))
          badvaddr <= bus.badvaddr;
      end else if (do_eret) begin
        status_exl <= 1'b0;
      end else if (do_mtc0) begin
        case (bus.addr)
          CR_STATUS: begin
            status_im  <= bus.wdata[15:8];
            status_exl <= bus.wdata[1];
            status_ie  <= bus.wdata[0];
          end
          CR_CAUSE: cause_ip_sw <= bus.wdata[9:8];
          CR_EPC:   epc         <= bus.wdata;
          default: ;
        endcase
      end
    end
  end

  logic [31:0] status_val, cause_val;
  assign status_val = {9'd0, 1'b1, 6'd0, status_im, 6'd0, status_exl, status_ie};
  assign cause_val  = {cause_bd, 15'd0, cause_ip_hw, cause_ip_sw, 1'b0, cause_excode, 2'b00};

  always_comb begin
    cp0_rdata = 32'd0;
    case (bus.addr)
      CR_BADVADDR: cp0_rdata = badvaddr;
      CR_COUNT:    cp0_rdata = count;
      CR_COMPARE:  cp0_rdata = compare;
      CR_STATUS:   cp0_rdata = status_val;
      CR_CAUSE:    cp0_rdata = cause_val;
      CR_EPC:      cp0_rdata = epc;
      default:     cp0_rdata = 32'd0;
    endcase
  end

  assign cp0_epc = epc;
  assign has_int = (|({cause_ip_hw, cause_ip_sw} & status_im)) & status_ie & ~status_exl;

endmodule

// File: tb/tb_cp0_regfile.sv
// Directed bench for cp0_regfile with an expectation queue and a small timer model.
module tb_cp0_regfile;
  import cp0_regfile_pkg::*;

  logic        clk;
  logic        reset;
  logic [WB_TO_CP0_REGISTER_BUS_WD-1:0] bus;
  logic [5:0]  ext_int_in;
  logic [31:0] cp0_rdata;
  logic [31:0] cp0_epc;
  logic        has_int;

  logic        f_ex, f_bd, f_mtc0_we, f_eret;
  logic [4:0]  f_excode, f_addr;
  logic [31:0] f_badvaddr, f_pc, f_wdata;

  assign bus = {f_ex, f_excode, f_badvaddr, f_bd, f_pc, f_mtc0_we, f_addr, f_wdata, f_eret};

  cp0_regfile dut (
    .clk                    (clk),
    .reset                  (reset),
    .wb_to_cp0_register_bus (bus),
    .ext_int_in             (ext_int_in),
    .cp0_rdata              (cp0_rdata),
    .cp0_epc                (cp0_epc),
    .has_int                (has_int)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    int          sel;
    logic [31:0] exp;
    logic [31:0] mask;
  } exp_t;

  exp_t sb[$];
  int   n_pass  = 0;
  int   n_total = 0;

  // Timer reference: tick, Count, Compare, TI and the registered IP7 bit.
  logic        m_tick, m_ti, m_ip7;
  logic [31:0] m_count, m_compare;

  localparam int SEL_RDATA = 0;
  localparam int SEL_EPC   = 1;
  localparam int SEL_INT   = 2;

  task automatic push_exp(input string tag, input int sel, input logic [31:0] exp,
                          input logic [31:0] mask);
    exp_t e;
    e.tag = tag; e.sel = sel; e.exp = exp & mask; e.mask = mask;
    sb.push_back(e);
  endtask

  task automatic check_out();
    exp_t        e;
    logic [31:0] obs;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      case (e.sel)
        SEL_RDATA: obs = cp0_rdata;
        SEL_EPC:   obs = cp0_epc;
        default:   obs = {31'd0, has_int};
      endcase
      obs = obs & e.mask;
      n_total++;
      assert (obs === e.exp) n_pass++;
      else $error("FAIL %s: got %h expected %h", e.tag, obs, e.exp);
    end
  endtask

  task automatic rd(input logic [4:0] a, input string tag, input logic [31:0] exp,
                    input logic [31:0] mask = 32'hFFFF_FFFF);
    f_addr = a;
    push_exp(tag, SEL_RDATA, exp, mask);
    #1;
    check_out();
  endtask

  task automatic chk_int(input string tag, input logic exp);
    push_exp(tag, SEL_INT, {31'd0, exp}, 32'h1);
    #1;
    check_out();
  endtask

  task automatic chk_epc(input string tag, input logic [31:0] exp);
    push_exp(tag, SEL_EPC, exp, 32'hFFFF_FFFF);
    #1;
    check_out();
  endtask

  // Advance one clock; the timer model sees the same inputs the DUT samples.
  task automatic step();
    logic        wr, n_tick, n_ti, n_ip7;
    logic [31:0] n_count, n_compare;
    wr = f_mtc0_we && !f_ex && !f_eret;
    if (reset) begin
      n_tick = 1'b0; n_ti = 1'b0; n_ip7 = 1'b0; n_count = 32'd0; n_compare = 32'd0;
    end else begin
      n_tick    = ~m_tick;
      n_count   = (wr && f_addr == CR_COUNT) ? f_wdata : (m_tick ? m_count + 32'd1 : m_count);
      n_compare = (wr && f_addr == CR_COMPARE) ? f_wdata : m_compare;
      n_ti      = (wr && f_addr == CR_COMPARE) ? 1'b0 : ((m_count == m_compare) ? 1'b1 : m_ti);
      n_ip7     = ext_int_in[5] | m_ti;
    end
    @(posedge clk);
    #1;
    m_tick = n_tick; m_ti = n_ti; m_ip7 = n_ip7; m_count = n_count; m_compare = n_compare;
    f_ex = 1'b0; f_eret = 1'b0; f_mtc0_we = 1'b0;
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
    f_mtc0_we = 1'b1; f_addr = a; f_wdata = d;
    step();
  endtask

  task automatic raise(input logic [4:0] code, input logic bd, input logic [31:0] pc,
                       input logic [31:0] bva);
    f_ex = 1'b1; f_excode = code; f_bd = bd; f_pc = pc; f_badvaddr = bva;
    step();
  endtask

  initial begin
    reset = 1'b1; ext_int_in = 6'd0;
    f_ex = 0; f_bd = 0; f_mtc0_we = 0; f_eret = 0;
    f_excode = 0; f_addr = 0; f_badvaddr = 0; f_pc = 0; f_wdata = 0;
    m_tick = 0; m_ti = 0; m_ip7 = 0; m_count = 0; m_compare = 0;

    step(); step();
    reset = 1'b0;

    rd(CR_STATUS,   "rst_status",   32'h0040_0000);
    rd(CR_CAUSE,    "rst_cause",    32'h0);
    rd(CR_COUNT,    "rst_count",    32'h0);
    rd(CR_EPC,      "rst_epc_rd",   32'h0);
    rd(CR_BADVADDR, "rst_badvaddr", 32'h0);
    rd(5'd3,        "unimpl_read",  32'h0);
    chk_int("rst_has_int", 1'b0);
    chk_epc("rst_cp0_epc", 32'h0);

    // Timer match
    mtc0(CR_COMPARE, 32'd5);
    rd(CR_COMPARE, "compare_wr", 32'd5);
    for (int i = 0; i < 10; i++) begin
      step();
      rd(CR_COUNT, "count_run", m_count);
    end
    rd(CR_COUNT, "count_at_10", 32'd5);
    step();
    rd(CR_CAUSE, "ti_in_ip7", 32'h0000_8000);
    mtc0(CR_STATUS, 32'h0040_8001);
    rd(CR_STATUS, "status_im7_ie", 32'h0040_8001);
    chk_int("timer_int", 1'b1);
    mtc0(CR_COMPARE, 32'd100);
    chk_int("timer_int_lag", 1'b1);
    step();
    chk_int("timer_int_clr", 1'b0);
    rd(CR_CAUSE, "ip7_clr", 32'h0, 32'h0000_8000);

    // Write masks
    mtc0(CR_STATUS, 32'hFFFF_FFFF);
    rd(CR_STATUS, "status_mask", 32'h0040_FF03);
    chk_int("int_exl_block", 1'b0);
    mtc0(CR_STATUS, 32'h0);
    rd(CR_STATUS, "status_zero", 32'h0040_0000);
    mtc0(CR_CAUSE, 32'hFFFF_FFFF);
    rd(CR_CAUSE, "cause_mask", {16'h0, m_ip7, 15'h0300});
    mtc0(CR_STATUS, 32'h0040_0101);
    chk_int("sw_int", 1'b1);
    mtc0(CR_CAUSE, 32'h0);
    chk_int("sw_int_clr", 1'b0);
    mtc0(CR_STATUS, 32'h0);
    mtc0(CR_BADVADDR, 32'h0000_1234);
    rd(CR_BADVADDR, "badvaddr_ro", 32'h0);
    mtc0(5'd3, 32'hFFFF_FFFF);
    chk_epc("unimpl_wr_epc", 32'h0);

    // EPC write: not visible in its own cycle, visible next cycle
    f_mtc0_we = 1'b1; f_wdata = 32'h1111_2222;
    rd(CR_EPC, "epc_same_cycle", 32'h0);
    step();
    chk_epc("epc_next_cycle", 32'h1111_2222);

    // Count wrap still matches Compare
    mtc0(CR_COMPARE, 32'h0);
    mtc0(CR_COUNT, 32'hFFFF_FFFF);
    rd(CR_COUNT, "count_wr", 32'hFFFF_FFFF);
    for (int i = 0; i < 5; i++) begin
      step();
      rd(CR_COUNT, "wrap_count", m_count);
      rd(CR_CAUSE, "wrap_ip7", {16'h0, m_ip7, 15'h0}, 32'h0000_8000);
    end
    rd(CR_CAUSE, "wrap_ti", 32'h0000_8000, 32'h0000_8000);
    mtc0(CR_COMPARE, 32'd100);
    step();

    // Delay-slot exception
    raise(EXC_OV, 1'b1, 32'hBFC0_0104, 32'hDEAD_0000);
    chk_epc("ds_epc", 32'hBFC0_0100);
    rd(CR_CAUSE, "ds_cause", 32'h8000_0030, 32'h8000_007C);
    rd(CR_STATUS, "ds_status", 32'h0040_0002);
    rd(CR_BADVADDR, "ds_badvaddr", 32'h0);

    // Nested exception keeps EPC and BD
    raise(EXC_SYS, 1'b0, 32'h8000_0010, 32'h0);
    chk_epc("nest_epc", 32'hBFC0_0100);
    rd(CR_CAUSE, "nest_cause", 32'h8000_0020, 32'h8000_007C);

    // AdEL, then ERET with a stray MTC0 attached
    raise(EXC_ADEL, 1'b0, 32'h8000_0020, 32'h8000_0003);
    rd(CR_BADVADDR, "adel_badvaddr", 32'h8000_0003);
    f_ex = 1'b1; f_eret = 1'b1; f_excode = 5'h1f;
    f_mtc0_we = 1'b1; f_addr = CR_EPC; f_wdata = 32'h5555_5555;
    step();
    rd(CR_STATUS, "eret_status", 32'h0040_0000);
    chk_epc("eret_epc", 32'hBFC0_0100);
    rd(CR_CAUSE, "eret_cause", 32'h8000_0010, 32'h8000_007C);

    // AdES with EXL clear
    raise(EXC_ADES, 1'b0, 32'h8000_1000, 32'h0000_BEEF);
    chk_epc("ades_epc", 32'h8000_1000);
    rd(CR_BADVADDR, "ades_badvaddr", 32'h0000_BEEF);
    rd(CR_CAUSE, "ades_cause", 32'h0000_0014, 32'h8000_007C);
    f_ex = 1'b1; f_eret = 1'b1;
    step();

    // External interrupt
    mtc0(CR_STATUS, 32'h0040_0401);
    ext_int_in = 6'b000001;
    chk_int("ext_int_lag", 1'b0);
    step();
    rd(CR_CAUSE, "ext_ip2", 32'h0000_0400, 32'h0000_0400);
    chk_int("ext_int", 1'b1);
    raise(EXC_INT, 1'b0, 32'h8000_2000, 32'h0);
    chk_int("ext_int_exl", 1'b0);
    rd(CR_STATUS, "ext_status", 32'h0040_0403);
    chk_epc("ext_epc", 32'h8000_2000);

    // Reset overrides a simultaneous exception
    reset = 1'b1; ext_int_in = 6'd0;
    f_ex = 1'b1; f_excode = EXC_ADEL; f_badvaddr = 32'hFFFF_FFFF; f_pc = 32'h1234_5678;
    step();
    reset = 1'b0;
    rd(CR_STATUS, "mid_rst_status", 32'h0040_0000);
    rd(CR_BADVADDR, "mid_rst_badvaddr", 32'h0);
    rd(CR_CAUSE, "mid_rst_cause", 32'h0);
    rd(CR_COUNT, "mid_rst_count", 32'h0);
    chk_epc("mid_rst_epc", 32'h0);
    chk_int("mid_rst_int", 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
